// File: rtl/duck_pixel_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : duck_pixel_ctrl_if
//  Purpose  : Bundle of video-timing, game-event and sprite-ROM signals
//             exchanged between the duck sprite controller and its system.
//  Revision : 1.0  initial release
// ============================================================================
interface duck_pixel_ctrl_if #(
   parameter int ADDR_W = 12
) ();
   logic              frame_start;
   logic              pixel_valid;
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic [9:0]        duck_x;
   logic [9:0]        duck_y;
   logic              shot;
   logic              respawn;
   logic [ADDR_W-1:0] rom_addr;
   logic [23:0]       rom_data;
   logic              is_duck;
   logic [23:0]       duck_color;
   logic [1:0]        anim_state;

   // System side: drives timing, events and ROM data, consumes pixel results.
   modport master (
      output frame_start, pixel_valid, DrawX, DrawY, duck_x, duck_y,
             shot, respawn, rom_data,
      input  rom_addr, is_duck, duck_color, anim_state
   );

   // Controller side.
   modport slave (
      input  frame_start, pixel_valid, DrawX, DrawY, duck_x, duck_y,
             shot, respawn, rom_data,
      output rom_addr, is_duck, duck_color, anim_state
   );
endinterface
`default_nettype wire

// File: rtl/duck_pixel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : duck_pixel_ctrl
//  Purpose  : Duck sprite controller: per-frame position latch, bounding-box
//             hit test, sprite ROM addressing, colour-key transparency and
//             the flap / shot / fall animation state machine.
//  Revision : 1.0  initial release
// ============================================================================
module duck_pixel_ctrl #(
   parameter int          SPRITE_W    = 32,
   parameter int          SPRITE_H    = 32,
   parameter int          ROM_LAT     = 2,
   parameter int          FLAP_FRAMES = 8,
   parameter int          SHOT_FRAMES = 30,
   parameter logic [23:0] KEY_COLOR   = 24'hFF00FF,
   parameter int          ADDR_W      = 12
) (
   input  logic            Clk,
   input  logic            Reset_n,
   duck_pixel_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      FLY_A = 2'd0,
      FLY_B = 2'd1,
      SHOT  = 2'd2,
      FALL  = 2'd3
   } state_t;

   localparam int CNT_MAX = (FLAP_FRAMES > SHOT_FRAMES) ? FLAP_FRAMES : SHOT_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]  FLAP_LAST   = CNT_W'(FLAP_FRAMES - 1);
   localparam logic [CNT_W-1:0]  SHOT_LAST   = CNT_W'(SHOT_FRAMES - 1);
   localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SPRITE_W * SPRITE_H);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              shot_pend;
   logic              resp_pend;
   logic [9:0]        x_r;
   logic [9:0]        y_r;
   logic [ROM_LAT:0]  hit_pipe;
   logic [ADDR_W-1:0] addr_q;
   logic              is_duck_q;
   logic [23:0]       color_q;

   // Offsets are taken in 11 bits so a pixel left of / above the sprite
   // wraps to a large value and a box straddling column 1023 never aliases
   // onto column 0.
   logic [10:0]       dx;
   logic [10:0]       dy;
   logic              hit;
   logic [ADDR_W-1:0] addr_next;
   logic              show;

   assign dx   = {1'b0, bus.DrawX} - {1'b0, x_r};
   assign dy   = {1'b0, bus.DrawY} - {1'b0, y_r};
   assign hit  = bus.pixel_valid && (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));

   // The animation frame index is the state encoding itself.
   assign addr_next = ADDR_W'(state) * FRAME_WORDS
                    + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
                    + ADDR_W'(dx);

   assign show = hit_pipe[ROM_LAT] && (bus.rom_data != KEY_COLOR);

   // Latch sprite position once per frame so it is stable across the frame.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_r <= '0;
         y_r <= '0;
      end else if (bus.frame_start) begin
         x_r <= bus.duck_x;
         y_r <= bus.duck_y;
      end
   end

   // Issue the ROM read and carry the hit flag alongside the ROM latency.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         addr_q   <= '0;
         hit_pipe <= '0;
      end else begin
         if (hit) begin
            addr_q <= addr_next;
         end
         hit_pipe <= {hit_pipe[ROM_LAT-1:0], hit};
      end
   end

   // Final pixel stage: key-colour pixels are transparent.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         is_duck_q <= 1'b0;
         color_q   <= '0;
      end else begin
         is_duck_q <= show;
         color_q   <= show ? bus.rom_data : 24'h000000;
      end
   end

   // Animation FSM; state only moves on frame_start, events in between are
   // remembered as pending flags.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= FLY_A;
         cnt       <= '0;
         shot_pend <= 1'b0;
         resp_pend <= 1'b0;
      end else if (bus.frame_start) begin
         unique case (state)
            FLY_A, FLY_B: begin
               if (shot_pend || bus.shot) begin
                  state     <= SHOT;
                  cnt       <= '0;
                  shot_pend <= 1'b0;
               end else if (cnt == FLAP_LAST) begin
                  state <= (state == FLY_A) ? FLY_B : FLY_A;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHOT: begin
               if (cnt == SHOT_LAST) begin
                  state <= FALL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FALL: begin
               if (resp_pend || bus.respawn) begin
                  state     <= FLY_A;
                  cnt       <= '0;
                  resp_pend <= 1'b0;
               end
            end
         endcase
      end else begin
         if (bus.shot && ((state == FLY_A) || (state == FLY_B))) begin
            shot_pend <= 1'b1;
         end
         if (bus.respawn && (state == FALL)) begin
            resp_pend <= 1'b1;
         end
      end
   end

   assign bus.rom_addr   = addr_q;
   assign bus.is_duck    = is_duck_q;
   assign bus.duck_color = color_q;
   assign bus.anim_state = state;

endmodule
`default_nettype wire
